// File: rtl/alu_wide_sequencer_if.sv
// Request/response bundle between the core and the wide ALU sequencer.
// The core side is the master; the sequencer is the slave.
interface alu_wide_sequencer_if #(
    parameter int WIDTH_BYTES = 2
);
    logic                     start;
    logic [2:0]               op;
    logic [8*WIDTH_BYTES-1:0] a;
    logic [8*WIDTH_BYTES-1:0] b;
    logic                     carry_in;
    logic                     busy;
    logic                     done;
    logic [8*WIDTH_BYTES-1:0] result;
    logic                     flag_zero;
    logic                     flag_carry;

    modport master (
        output start, op, a, b, carry_in,
        input  busy, done, result, flag_zero, flag_carry
    );

    modport slave (
        input  start, op, a, b, carry_in,
        output busy, done, result, flag_zero, flag_carry
    );
endinterface

// File: rtl/alu_wide_sequencer.sv
// Runs one multi-byte ADD/SUB/AND/OR/XOR as WIDTH_BYTES passes through the 8-bit
// combinational ALU, least-significant byte first, chaining the carry between passes.
module alu_wide_sequencer #(
    parameter int WIDTH_BYTES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_wide_sequencer_if.slave        bus,
    output logic [7:0]                 alu_operand_a,
    output logic [7:0]                 alu_operand_b,
    output logic                       alu_carry_in,
    output logic [2:0]                 alu_operator,
    input  logic [7:0]                 alu_result,
    input  logic                       alu_flag_zero,
    input  logic                       alu_flag_carry
);
    // Operator encodings shared with the ALU (alu_defs.vh)
    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;

    localparam int IDX_W = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic [WIDTH_BYTES-1:0][7:0]     a_q;
    logic [WIDTH_BYTES-1:0][7:0]     b_q;
    logic [WIDTH_BYTES-1:0][7:0]     result_q;
    logic [2:0]                      op_q;
    logic                            cin_q;
    logic                            chain_carry;
    logic                            zero_acc;
    logic                            busy_q;
    logic                            done_q;
    logic                            flag_zero_q;
    logic                            flag_carry_q;
    logic                            op_is_arith;

    assign op_is_arith = (op_q == ALU_OP_ADD) || (op_q == ALU_OP_SUB);

    // Only ADD/SUB propagate a carry; logic ops always see carry_in = 0
    always_comb begin
        alu_operand_a = 8'h00;
        alu_operand_b = 8'h00;
        alu_carry_in  = 1'b0;
        alu_operator  = op_q;
        if (state == S_RUN) begin
            alu_operand_a = a_q[idx];
            alu_operand_b = b_q[idx];
            alu_carry_in  = op_is_arith & ((idx == '0) ? cin_q : chain_carry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            op_q         <= 3'd0;
            cin_q        <= 1'b0;
            chain_carry  <= 1'b0;
            zero_acc     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q          <= bus.a;
                        b_q          <= bus.b;
                        op_q         <= bus.op;
                        cin_q        <= bus.carry_in;
                        result_q     <= '0;
                        zero_acc     <= 1'b1;
                        chain_carry  <= 1'b0;
                        flag_zero_q  <= 1'b0;
                        flag_carry_q <= 1'b0;
                        idx          <= '0;
                        busy_q       <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[idx] <= alu_result;
                    zero_acc      <= zero_acc & alu_flag_zero;
                    chain_carry   <= alu_flag_carry;
                    if (idx == LAST_IDX) begin
                        flag_zero_q  <= zero_acc & alu_flag_zero;
                        flag_carry_q <= op_is_arith & alu_flag_carry;
                        done_q       <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = flag_zero_q;
    assign bus.flag_carry = flag_carry_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Randomized self-checking bench for alu_wide_sequencer with a behavioural 8-bit ALU
// and a whole-word reference model.
module tb_alu_wide_sequencer;
    localparam int W  = 2;
    localparam int RW = 8 * W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_operand_a;
    logic [7:0] alu_operand_b;
    logic       alu_carry_in;
    logic [2:0] alu_operator;
    logic [7:0] alu_result;
    logic       alu_flag_zero;
    logic       alu_flag_carry;
    logic [8:0] alu_wide;

    int checks   = 0;
    int failures = 0;

    alu_wide_sequencer_if #(.WIDTH_BYTES(W)) bus ();

    alu_wide_sequencer #(.WIDTH_BYTES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .alu_operand_a  (alu_operand_a),
        .alu_operand_b  (alu_operand_b),
        .alu_carry_in   (alu_carry_in),
        .alu_operator   (alu_operator),
        .alu_result     (alu_result),
        .alu_flag_zero  (alu_flag_zero),
        .alu_flag_carry (alu_flag_carry)
    );

    always #5 clk = ~clk;

    // Stand-in for the external 8-bit ALU; unknown ops return a ^ ~b with carry forced high
    always_comb begin
        alu_wide       = 9'd0;
        alu_result     = 8'h00;
        alu_flag_carry = 1'b0;
        case (alu_operator)
            OP_ADD: begin
                alu_wide       = {1'b0, alu_operand_a} + {1'b0, alu_operand_b} + 9'(alu_carry_in);
                alu_result     = alu_wide[7:0];
                alu_flag_carry = alu_wide[8];
            end
            OP_SUB: begin
                alu_wide       = {1'b0, alu_operand_a} - {1'b0, alu_operand_b} - 9'(alu_carry_in);
                alu_result     = alu_wide[7:0];
                alu_flag_carry = alu_wide[8];
            end
            OP_AND:  alu_result = alu_operand_a & alu_operand_b;
            OP_OR:   alu_result = alu_operand_a | alu_operand_b;
            OP_XOR:  alu_result = alu_operand_a ^ alu_operand_b;
            default: begin
                alu_result     = alu_operand_a ^ ~alu_operand_b;
                alu_flag_carry = 1'b1;
            end
        endcase
        alu_flag_zero = (alu_result == 8'h00);
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Whole-word arithmetic; pass carries come from the carry out of the lower k bytes
    function automatic void ref_model(input logic [2:0] op_v, input logic [RW-1:0] a_v,
                                      input logic [RW-1:0] b_v, input logic cin_v,
                                      output logic [RW-1:0] r, output logic z, output logic c,
                                      output logic [W-1:0] pcin);
        longint unsigned av, bv, cv, m, full;
        av = 64'(a_v);
        bv = 64'(b_v);
        cv = 64'(cin_v);
        c  = 1'b0;
        case (op_v)
            OP_ADD: begin
                full = av + bv + cv;
                r    = RW'(full);
                c    = (full >> RW) != 0;
            end
            OP_SUB: begin
                r = RW'(av - bv - cv);
                c = av < (bv + cv);
            end
            OP_AND:  r = a_v & b_v;
            OP_OR:   r = a_v | b_v;
            OP_XOR:  r = a_v ^ b_v;
            default: r = a_v ^ ~b_v;
        endcase
        z = (r == '0);
        for (int k = 0; k < W; k++) begin
            m = (64'(1) << (8 * k)) - 1;
            if (op_v == OP_ADD)
                pcin[k] = (((av & m) + (bv & m) + cv) >> (8 * k)) != 0;
            else if (op_v == OP_SUB)
                pcin[k] = (av & m) < ((bv & m) + cv);
            else
                pcin[k] = 1'b0;
        end
    endfunction

    task automatic apply_stimulus(input logic [2:0] op_v, input logic [RW-1:0] a_v,
                                  input logic [RW-1:0] b_v, input logic cin_v, input bit reissue);
        logic [RW-1:0] exp_r;
        logic          exp_z, exp_c;
        logic [W-1:0]  exp_pcin;
        int            cyc;
        bit            seen;
        ref_model(op_v, a_v, b_v, cin_v, exp_r, exp_z, exp_c, exp_pcin);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op_v;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.carry_in = cin_v;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.a        = RW'($urandom);
        bus.b        = RW'($urandom);
        bus.op       = 3'($urandom_range(0, 7));
        bus.carry_in = 1'($urandom);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= W + 4) begin
            if (cyc <= W) begin
                check_output("pass_opa", alu_operand_a, a_v[8*(cyc-1) +: 8]);
                check_output("pass_cin", alu_carry_in, exp_pcin[cyc-1]);
            end
            check_output("busy", bus.busy, 1);
            if (bus.done) seen = 1'b1;
            if (reissue) begin
                bus.start = 1'b1;
                bus.a     = RW'($urandom);
                bus.b     = RW'($urandom);
            end
            if (!seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        check_output("done_cycle", cyc, W + 1);
        check_output("result", bus.result, exp_r);
        check_output("flag_zero", bus.flag_zero, exp_z);
        check_output("flag_carry", bus.flag_carry, exp_c);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("done_pulse", bus.done, 0);
        check_output("idle_busy", bus.busy, 0);
        check_output("result_hold", bus.result, exp_r);
        if (reissue) begin
            @(negedge clk);
            check_output("dropped_busy", bus.busy, 0);
            check_output("dropped_result", bus.result, exp_r);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_seen;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
        #12;
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_done", bus.done, 0);
        check_output("rst_result", bus.result, 0);
        check_output("rst_flag_zero", bus.flag_zero, 0);
        check_output("rst_flag_carry", bus.flag_carry, 0);
        check_output("rst_alu_opa", alu_operand_a, 0);
        check_output("rst_alu_op", alu_operator, 0);
        check_output("rst_alu_cin", alu_carry_in, 0);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(OP_SUB, 16'h0000, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(OP_AND, 16'hF0F0, 16'h0F0F, 1'b1, 1'b0);
        apply_stimulus(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1);
        apply_stimulus(OP_ADD, 16'h1234, 16'h0001, 1'b1, 1'b0);
        apply_stimulus(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);

        // Reset during the second pass leaves flags from the previous Z=1/C=1 result to be cleared
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h0101;
        bus.b     = 16'h0101;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("midrun_busy", bus.busy, 0);
        check_output("midrun_result", bus.result, 0);
        check_output("midrun_flag_zero", bus.flag_zero, 0);
        check_output("midrun_flag_carry", bus.flag_carry, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check_output("midrun_no_done", done_seen, 0);
        apply_stimulus(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            apply_stimulus(3'($urandom_range(0, 7)), RW'($urandom), RW'($urandom),
                           1'($urandom), bit'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
